// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: glyph table and blanking code.
// Latency: none (constants only).
// Backpressure: none.
package seg_pkg;

    // All segments off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Brightness code that keeps the digit lit for the whole slot.
    localparam logic [3:0] BRIGHT_FULL = 4'd15;

    // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g.
    // Element 0 is the rightmost entry: 0,1,2,3,4,5,6,7,8,9,A,b,C,d,E,F.
    localparam logic [15:0][6:0] SEG_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-low seven-segment glyph.
// Latency: combinational.
// Backpressure: none.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    // Straight table lookup; every one of the 16 codes has a glyph.
    always_comb begin
        seg_n = SEG_GLYPH[hex];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-digit enable, blink, dp and PWM dimming.
// Latency: an_n/seg_n/dp_n registered, one clock after the prescaler/index state that selects them.
// Backpressure: none; inputs are captured into shadows once per frame. Option: SEG_LZ_SUPPRESS_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIGITS = 8,
    parameter int DIV_W   = 16,
    parameter int BLINK_W = 6
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NDIGITS-1:0]     en,
    input  logic [4*NDIGITS-1:0]   digits,
    input  logic [NDIGITS-1:0]     dp,
    input  logic [NDIGITS-1:0]     blink,
    input  logic [3:0]             bright,
    output logic [NDIGITS-1:0]     an_n,
    output logic [6:0]             seg_n,
    output logic                   dp_n,
    output logic                   frame_tick
);

    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

    logic [DIV_W-1:0]     presc;
    logic [IDX_W-1:0]     idx;
    logic [BLINK_W-1:0]   frame_cnt;
    logic                 slot_end;
    logic                 frame_end;
    logic                 blink_phase;
    logic                 pwm_on;

    logic [NDIGITS-1:0]   en_sh;
    logic [4*NDIGITS-1:0] dig_sh;
    logic [NDIGITS-1:0]   dp_sh;
    logic [NDIGITS-1:0]   blink_sh;

    logic [NDIGITS-1:0]   show_mask;
    logic                 sel_en;
    logic                 sel_dp;
    logic                 sel_blink;
    logic [3:0]           sel_nib;
    logic [6:0]           seg_dec;
    logic                 lit;

    assign slot_end    = &presc;
    assign frame_end   = slot_end && (idx == LAST_IDX);
    assign blink_phase = frame_cnt[BLINK_W-1];
    // bright = 15 keeps every slot phase lit; bright = 0 lights only the first 1/16.
    assign pwm_on      = (bright == BRIGHT_FULL) || (presc[DIV_W-1 -: 4] <= bright);

    // Prescaler, digit index, frame counter and end-of-frame pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc      <= '0;
            idx        <= '0;
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
        end else begin
            presc      <= presc + 1'b1;
            frame_tick <= frame_end;
            // Counter moves on the same edge that raises frame_tick, so the
            // blink phase is already settled for the first slot of the new frame.
            if (frame_end) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (slot_end) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Shadow capture at frame boundaries so a frame never mixes old and new data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_sh    <= '0;
            dig_sh   <= '0;
            dp_sh    <= '0;
            blink_sh <= '0;
        end else if (frame_end) begin
            en_sh    <= en;
            dig_sh   <= digits;
            dp_sh    <= dp;
            blink_sh <= blink;
        end
    end

`ifdef SEG_LZ_SUPPRESS_EN
    // Blank digits above the most-significant nonzero nibble; digit 0 and dp digits always stay.
    always_comb begin
        logic seen;
        seen      = 1'b0;
        show_mask = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            seen         = seen | (dig_sh[4*i +: 4] != 4'h0);
            show_mask[i] = seen | dp_sh[i] | (i == 0);
        end
    end
`else
    assign show_mask = '1;
`endif

    // Select the shadow fields of the digit currently being scanned.
    always_comb begin
        sel_en    = 1'b0;
        sel_dp    = 1'b0;
        sel_blink = 1'b0;
        sel_nib   = 4'h0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_en    = en_sh[i] & show_mask[i];
                sel_dp    = dp_sh[i];
                sel_blink = blink_sh[i];
                sel_nib   = dig_sh[4*i +: 4];
            end
        end
    end

    seg_hex_decode u_hex_decode (
        .hex   (sel_nib),
        .seg_n (seg_dec)
    );

    assign lit = sel_en && pwm_on && !(sel_blink && blink_phase);

    // Registered drive of anodes/segments; everything dark when the digit is unlit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            an_n  <= '1;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end else if (lit) begin
            an_n  <= ~(NDIGITS'(1) << idx);
            seg_n <= seg_dec;
            dp_n  <= ~sel_dp;
        end else begin
            an_n  <= '1;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end
    end

endmodule
